fifo_stream_reader: RTL and testbench

- Read-side adapter for the synchronous FIFO used in the router input buffers.
- The FIFO presents registered read data one cycle after an accepted read strobe. This block hides that latency and converts the FIFO read port into a valid/ready stream toward the crossbar/output stage.
- It prefetches into a 2-entry output buffer, so it sustains 1 word/cycle under continuous ready and never loses a word under back-pressure.

---
 rtl/fifo_stream_reader.sv | 83 ++++++++
 tb/tb_fifo_stream_reader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side adapter that hides the FIFO's one-cycle read latency behind a two-entry
// prefetch buffer and presents the words as a valid/ready stream.
module fifo_stream_reader #(
    parameter int NUM_BITS = 32,
    parameter int COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    input  logic [NUM_BITS-1:0] fifo_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] out_data,
    output logic [COUNT_W-1:0]  word_count,
    output logic                idle
);

    logic [1:0]          occ_q, occ_d;
    logic                pend_q;
    logic [NUM_BITS-1:0] head_q, head_d;
    logic [NUM_BITS-1:0] tail_q, tail_d;
    logic [COUNT_W-1:0]  count_q;
    logic                pop;
    logic [2:0]          committed;

    assign out_valid  = (occ_q != 2'd0);
    assign out_data   = head_q;
    assign word_count = count_q;
    assign idle       = (occ_q == 2'd0) && !pend_q && fifo_empty;
    assign pop        = out_valid && out_ready;

    // Slots already spoken for: buffered words plus the word in flight, less the one leaving now.
    assign committed  = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
    assign fifo_rd_en = enable && !fifo_empty && !rst && (committed < 3'd2);

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (pend_q) begin
            if (pop) begin
                // The old tail moves up to head; the arriving word fills the first free slot.
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = fifo_data;
                end else begin
                    head_d = fifo_data;
                end
            end else begin
                if (occ_q == 2'd0) begin
                    head_d = fifo_data;
                end else begin
                    tail_d = fifo_data;
                end
                occ_d = occ_q + 2'd1;
            end
        end else if (pop) begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= 2'd0;
            pend_q  <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            occ_q  <= occ_d;
            pend_q <= fifo_rd_en;
            head_q <= head_d;
            tail_q <= tail_d;
            if (pop) begin
                count_q <= count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds the DUT and a
// scoreboard checks delivery order, word count and the read-strobe rules.
module tb_fifo_stream_reader;

    localparam int NB = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifoEmpty;
    logic          fifoRdEn;
    logic [NB-1:0] fifoData;
    logic          outValid;
    logic          outReady;
    logic [NB-1:0] outData;
    logic [CW-1:0] wordCount;
    logic          idle;

    logic [NB-1:0] fifoQ[$];
    logic [NB-1:0] expQ[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            modelCount  = 0;
    int            rdCount     = 0;
    int            rdBase;
    int            pushed;
    int            cyc;
    bit            sbOn        = 1'b1;
    bit            rdSeen      = 1'b0;

    fifo_stream_reader #(.NUM_BITS(NB), .COUNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifoEmpty),
        .fifo_rd_en (fifoRdEn),
        .fifo_data  (fifoData),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_data   (outData),
        .word_count (wordCount),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pushWord(input logic [NB-1:0] w);
        fifoQ.push_back(w);
        expQ.push_back(w);
        fifoEmpty = 1'b0;
    endtask

    // Negedge sampling: strobe legality, then the stream scoreboard.
    task automatic sampleNeg();
        @(negedge clk);
        rdSeen = fifoRdEn;
        if (fifoRdEn) rdCount++;
        checkOutput("rd_en_while_empty", fifoRdEn & fifoEmpty, 0);
        if (sbOn) begin
            checkOutput("word_count", wordCount, modelCount);
            if (outValid && outReady) begin
                checkOutput("word_available", (expQ.size() != 0), 1);
                if (expQ.size() != 0) checkOutput("data_order", outData, expQ.pop_front());
                modelCount = (modelCount + 1) % (1 << CW);
            end
        end
    endtask

    // The FIFO model presents its registered read data after the edge that accepted the strobe.
    task automatic nextCycle();
        @(posedge clk);
        #1;
        if (rdSeen && fifoQ.size() != 0) fifoData = fifoQ.pop_front();
        fifoEmpty = (fifoQ.size() == 0);
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            sampleNeg();
            nextCycle();
        end
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        outReady  = 1'b1;
        fifoEmpty = 1'b1;
        fifoData  = '0;
        @(posedge clk);
        #1;

        $display("[TB] reset values and single word");
        sampleNeg();
        checkOutput("reset_valid", outValid, 0);
        checkOutput("reset_data", outData, 0);
        checkOutput("reset_count", wordCount, 0);
        checkOutput("reset_rd_en", fifoRdEn, 0);
        checkOutput("reset_idle", idle, 1);
        nextCycle();
        pushWord(32'hA5);
        sampleNeg();
        checkOutput("reset_rd_blocked", fifoRdEn, 0);
        checkOutput("reset_idle_nonempty", idle, 0);
        nextCycle();
        rst = 1'b0;
        sampleNeg();
        checkOutput("single_rd_c0", fifoRdEn, 1);
        checkOutput("single_valid_c0", outValid, 0);
        nextCycle();
        sampleNeg();
        checkOutput("single_rd_c1", fifoRdEn, 0);
        checkOutput("single_valid_c1", outValid, 0);
        nextCycle();
        sampleNeg();
        checkOutput("single_valid_c2", outValid, 1);
        checkOutput("single_data_c2", outData, 32'hA5);
        nextCycle();
        sampleNeg();
        checkOutput("single_valid_c3", outValid, 0);
        checkOutput("single_count_c3", wordCount, 1);
        checkOutput("single_idle_c3", idle, 1);
        nextCycle();

        $display("[TB] streaming");
        for (int i = 1; i <= 8; i++) pushWord(NB'(i));
        for (int c = 0; c <= 10; c++) begin
            sampleNeg();
            checkOutput("stream_rd", fifoRdEn, (c < 8));
            checkOutput("stream_valid", outValid, (c >= 2 && c <= 9));
            if (c >= 2 && c <= 9) checkOutput("stream_data", outData, c - 1);
            nextCycle();
        end
        checkOutput("stream_count", wordCount, 9);

        $display("[TB] back-pressure");
        outReady = 1'b0;
        rdBase   = rdCount;
        for (int i = 1; i <= 8; i++) pushWord(32'h100 + NB'(i));
        for (int c = 0; c <= 9; c++) begin
            sampleNeg();
            checkOutput("bp_valid", outValid, (c >= 2));
            if (c >= 2) checkOutput("bp_data_hold", outData, 32'h101);
            nextCycle();
        end
        checkOutput("bp_reads_held", rdCount - rdBase, 2);
        checkOutput("bp_not_idle", idle, 0);
        outReady = 1'b1;
        for (int c = 10; c <= 18; c++) begin
            sampleNeg();
            checkOutput("bp_release_valid", outValid, (c <= 17));
            if (c <= 17) checkOutput("bp_release_data", outData, 32'h100 + c - 9);
            nextCycle();
        end
        checkOutput("bp_reads_total", rdCount - rdBase, 8);
        checkOutput("bp_count", wordCount, 17);

        $display("[TB] enable deassertion with a word in flight");
        for (int i = 1; i <= 4; i++) pushWord(32'h200 + NB'(i));
        applyStimulus(2);
        enable   = 1'b0;
        outReady = 1'b0;
        sampleNeg();
        checkOutput("en_rd_c2", fifoRdEn, 0);
        checkOutput("en_data_c2", outData, 32'h201);
        nextCycle();
        sampleNeg();
        checkOutput("en_rd_c3", fifoRdEn, 0);
        checkOutput("en_valid_c3", outValid, 1);
        checkOutput("en_data_c3", outData, 32'h201);
        nextCycle();
        outReady = 1'b1;
        sampleNeg();
        checkOutput("en_rd_c4", fifoRdEn, 0);
        checkOutput("en_data_c4", outData, 32'h201);
        nextCycle();
        sampleNeg();
        checkOutput("en_rd_c5", fifoRdEn, 0);
        checkOutput("en_data_c5", outData, 32'h202);
        nextCycle();
        sampleNeg();
        checkOutput("en_rd_c6", fifoRdEn, 0);
        checkOutput("en_valid_c6", outValid, 0);
        nextCycle();
        enable = 1'b1;
        applyStimulus(6);
        checkOutput("en_drained", expQ.size(), 0);
        checkOutput("en_count", wordCount, 21);

        $display("[TB] reset mid-stream");
        sbOn = 1'b0;
        for (int i = 1; i <= 8; i++) pushWord(32'h300 + NB'(i));
        applyStimulus(4);
        rst = 1'b1;
        sampleNeg();
        checkOutput("mid_rst_rd", fifoRdEn, 0);
        nextCycle();
        rst = 1'b0;
        sampleNeg();
        checkOutput("mid_rst_valid", outValid, 0);
        checkOutput("mid_rst_count", wordCount, 0);
        checkOutput("mid_rst_idle", idle, 0);
        checkOutput("mid_rst_rd_resume", fifoRdEn, 1);
        nextCycle();
        sampleNeg();
        checkOutput("mid_rst_valid_c6", outValid, 0);
        nextCycle();
        for (int c = 7; c <= 11; c++) begin
            sampleNeg();
            checkOutput("resume_valid", outValid, (c <= 10));
            if (c <= 10) checkOutput("resume_data", outData, 32'h305 + c - 7);
            nextCycle();
        end
        checkOutput("resume_count", wordCount, 4);
        checkOutput("resume_idle", idle, 1);
        expQ.delete();
        modelCount = 4;
        sbOn       = 1'b1;

        $display("[TB] random ready, enable and writes");
        pushed = 0;
        cyc    = 0;
        while ((pushed < 1000 || expQ.size() != 0) && cyc < 20000) begin
            if (pushed < 1000 && $urandom_range(0, 99) < 60) begin
                pushWord($urandom);
                pushed++;
            end
            outReady = 1'($urandom_range(0, 1));
            enable   = ($urandom_range(0, 9) != 0);
            applyStimulus(1);
            cyc++;
        end
        checkOutput("random_all_delivered", expQ.size(), 0);
        checkOutput("random_pushed", pushed, 1000);
        applyStimulus(3);
        checkOutput("random_final_idle", idle, 1);
        checkOutput("random_final_count", wordCount, modelCount);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
